// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding,
// flag-vector bit positions and the helper that derives all six flags.
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int F_EQU = 0;
   localparam int F_NEQ = 1;
   localparam int F_GTH = 2;
   localparam int F_LTH = 3;
   localparam int F_GTE = 4;
   localparam int F_LTE = 5;
   localparam int NFLAG = 6;

   // Everything follows from "equal" and "less than"; exactly one of equ/gth/lth ends up set.
   function automatic logic [NFLAG-1:0] flags_from(input logic equ, input logic lth);
      logic [NFLAG-1:0] f;
      f        = '0;
      f[F_EQU] = equ;
      f[F_NEQ] = ~equ;
      f[F_GTH] = ~lth & ~equ;
      f[F_LTH] = lth;
      f[F_GTE] = ~lth;
      f[F_LTE] = lth | equ;
      return f;
   endfunction

endpackage

// File: rtl/sub_slice.sv
// One SLICE-bit subtract step: a + ~b + cin as a ripple of full-adder cells.
// cin_msb is the carry into the top cell, needed for signed overflow detection.
module sub_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout,
   output logic             cin_msb
);

   logic [SLICE:0]   c;
   logic [SLICE-1:0] nb;

   always_comb begin
      nb   = ~b;
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
         s[i]   = a[i] ^ nb[i] ^ c[i];
         c[i+1] = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
      end
   end

   assign cout    = c[SLICE];
   assign cin_msb = c[SLICE-1];

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle magnitude comparator: A-B computed one SLICE-bit slice per clock,
// LSB first, then registered compare flags and difference for signed/unsigned operands.
module cmp_seq
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iSigned,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oDiff,
   output logic             oEqu,
   output logic             oNeq,
   output logic             oGth,
   output logic             oLth,
   output logic             oGte,
   output logic             oLte,
   output state_t           oState
);

   localparam int NSL  = WIDTH / SLICE;
   localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

   generate
      if ((WIDTH < 2) || (SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
         $error("cmp_seq: WIDTH must be >= 2 and a multiple of SLICE");
      end
   endgenerate

   // Handshake: iStart is a request sampled only in IDLE or DONE; oDone is a
   // one-cycle result-valid pulse and needs no acknowledge; results then hold.
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, b_q, work_q, work_n, diff_q;
   logic              sgn_q, carry_q, zacc_q;
   logic [IDXW-1:0]   idx_q;
   logic [NFLAG-1:0]  flags_q;

   logic              load, step, fin, last;
   logic [WIDTH-1:0]  a_sh, b_sh;
   logic [SLICE-1:0]  sl_a, sl_b, sl_s;
   logic              sl_cout, sl_cin_msb;
   logic              sl_zero, equ_n, lth_n;

   assign last = (idx_q == IDXW'(NSL - 1));
   assign a_sh = a_q >> (int'(idx_q) * SLICE);
   assign b_sh = b_q >> (int'(idx_q) * SLICE);
   assign sl_a = a_sh[SLICE-1:0];
   assign sl_b = b_sh[SLICE-1:0];

   sub_slice #(.SLICE(SLICE)) u_slice (
      .a       (sl_a),
      .b       (sl_b),
      .cin     (carry_q),
      .s       (sl_s),
      .cout    (sl_cout),
      .cin_msb (sl_cin_msb)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) begin
               fin     = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (iStart) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Only meaningful on the final slice, where sl_s is the top slice of the difference.
   always_comb begin
      work_n = work_q;
      work_n[int'(idx_q) * SLICE +: SLICE] = sl_s;
      sl_zero = (sl_s == '0);
      equ_n   = zacc_q & sl_zero;
      lth_n   = sgn_q ? (sl_s[SLICE-1] ^ sl_cin_msb ^ sl_cout) : ~sl_cout;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
         idx_q   <= '0;
         work_q  <= '0;
         diff_q  <= '0;
         flags_q <= '0;
      end else if (load) begin
         a_q     <= iA;
         b_q     <= iB;
         sgn_q   <= iSigned;
         carry_q <= 1'b1;
         zacc_q  <= 1'b1;
         idx_q   <= '0;
      end else if (step) begin
         carry_q <= sl_cout;
         zacc_q  <= zacc_q & sl_zero;
         work_q  <= work_n;
         if (fin) begin
            idx_q   <= '0;
            diff_q  <= work_n;
            flags_q <= flags_from(equ_n, lth_n);
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign oBusy  = (state_q == ST_RUN);
   assign oDone  = (state_q == ST_DONE);
   assign oState = state_q;
   assign oDiff  = diff_q;
   assign oEqu   = flags_q[F_EQU];
   assign oNeq   = flags_q[F_NEQ];
   assign oGth   = flags_q[F_GTH];
   assign oLth   = flags_q[F_LTH];
   assign oGte   = flags_q[F_GTE];
   assign oLte   = flags_q[F_LTE];

endmodule

// File: tb/tb_cmp_seq.sv
// Bench for cmp_seq: a 4-bit-slice and a full-width-slice instance checked
// against an arithmetic reference of the compare.
module tb_cmp_seq;
   import cmp_pkg::*;

   logic        iClk = 1'b0;
   logic        iRst, iStart4, iStart16, iSigned;
   logic [15:0] iA, iB;

   logic        d4_busy, d4_done, d4_equ, d4_neq, d4_gth, d4_lth, d4_gte, d4_lte;
   logic        d16_busy, d16_done, d16_equ, d16_neq, d16_gth, d16_lth, d16_gte, d16_lte;
   logic [15:0] d4_diff, d16_diff;
   state_t      d4_state, d16_state;
   logic [5:0]  f4, f16;

   int errors = 0;
   int checks = 0;

   always #5 iClk = ~iClk;

   cmp_seq #(.WIDTH(16), .SLICE(4)) u_dut4 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart4), .iSigned(iSigned), .iA(iA), .iB(iB),
      .oBusy(d4_busy), .oDone(d4_done), .oDiff(d4_diff), .oEqu(d4_equ), .oNeq(d4_neq),
      .oGth(d4_gth), .oLth(d4_lth), .oGte(d4_gte), .oLte(d4_lte), .oState(d4_state)
   );

   cmp_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart16), .iSigned(iSigned), .iA(iA), .iB(iB),
      .oBusy(d16_busy), .oDone(d16_done), .oDiff(d16_diff), .oEqu(d16_equ), .oNeq(d16_neq),
      .oGth(d16_gth), .oLth(d16_lth), .oGte(d16_gte), .oLte(d16_lte), .oState(d16_state)
   );

   // Flag vector order: {lte, gte, lth, gth, neq, equ}
   assign f4  = {d4_lte, d4_gte, d4_lth, d4_gth, d4_neq, d4_equ};
   assign f16 = {d16_lte, d16_gte, d16_lth, d16_gth, d16_neq, d16_equ};

   function automatic logic [5:0] ref_flags(input logic [15:0] a, input logic [15:0] b,
                                            input logic sg);
      bit eq, lt;
      eq = (a == b);
      lt = sg ? ($signed(a) < $signed(b)) : (a < b);
      return {lt | eq, !lt, lt, !lt && !eq, !eq, eq};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input logic sg);
      iA = a; iB = b; iSigned = sg;
      if (sel) iStart16 = 1'b1; else iStart4 = 1'b1;
      @(posedge iClk); #1;
      iStart4 = 1'b0; iStart16 = 1'b0;
   endtask

   task automatic wait_check(input bit sel, input logic [15:0] a, input logic [15:0] b,
                             input logic sg, input string tag, input bit pulse_chk);
      int n;
      bit seen;
      logic [15:0] exp_diff;
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(posedge iClk); #1;
         n++;
         seen = sel ? d16_done : d4_done;
      end
      exp_diff = a - b;
      check({tag, "_latency"}, n, sel ? 1 : 4);
      check({tag, "_diff"}, sel ? d16_diff : d4_diff, exp_diff);
      check({tag, "_flags"}, sel ? f16 : f4, ref_flags(a, b, sg));
      check({tag, "_busy_at_done"}, sel ? d16_busy : d4_busy, 0);
      if (pulse_chk) begin
         @(posedge iClk); #1;
         check({tag, "_done_pulse"}, sel ? d16_done : d4_done, 0);
         check({tag, "_diff_hold"}, sel ? d16_diff : d4_diff, exp_diff);
      end
   endtask

   initial begin
      logic [15:0] a, b, ha, hb;
      logic        sg;
      int          extra;

      iRst = 1'b1; iStart4 = 1'b0; iStart16 = 1'b0; iSigned = 1'b0;
      iA = 16'h1234; iB = 16'h4321;
      repeat (3) @(posedge iClk);
      #1;
      check("rst_busy4", d4_busy, 0);
      check("rst_done4", d4_done, 0);
      check("rst_diff4", d4_diff, 0);
      check("rst_flags4", f4, 0);
      check("rst_flags16", {d16_busy, d16_done, d16_diff, f16}, 0);
      iRst = 1'b0;
      @(posedge iClk); #1;

      // Directed cases from the block's intended usage
      launch(0, 16'h8000, 16'h0001, 0); wait_check(0, 16'h8000, 16'h0001, 0, "u_8000_0001", 1);
      check("u_8000_0001_const", {d4_diff, f4}, {16'h7FFF, 6'b010110});
      launch(0, 16'h8000, 16'h0001, 1); wait_check(0, 16'h8000, 16'h0001, 1, "s_8000_0001", 1);
      check("s_8000_0001_const", {d4_diff, f4}, {16'h7FFF, 6'b101010});
      launch(0, 16'hBEEF, 16'hBEEF, 0); wait_check(0, 16'hBEEF, 16'hBEEF, 0, "u_beef", 1);
      launch(0, 16'hBEEF, 16'hBEEF, 1); wait_check(0, 16'hBEEF, 16'hBEEF, 1, "s_beef", 1);
      check("s_beef_const", {d4_diff, f4}, {16'h0000, 6'b110001});
      launch(0, 16'h7FFF, 16'h8000, 1); wait_check(0, 16'h7FFF, 16'h8000, 1, "s_7fff_8000", 1);
      check("s_7fff_8000_gth", d4_gth, 1);
      launch(0, 16'h7FFF, 16'h8000, 0); wait_check(0, 16'h7FFF, 16'h8000, 0, "u_7fff_8000", 1);
      check("u_7fff_8000_const", {d4_diff, d4_lth}, {16'hFFFF, 1'b1});
      launch(0, 16'hFFFF, 16'h0000, 1); wait_check(0, 16'hFFFF, 16'h0000, 1, "s_ffff_0", 1);
      launch(0, 16'h0000, 16'hFFFF, 0); wait_check(0, 16'h0000, 16'hFFFF, 0, "u_0_ffff", 1);

      // Results hold while idle even with operands changing
      iA = 16'h5555; iB = 16'h0001;
      repeat (4) @(posedge iClk);
      #1;
      check("hold_diff", d4_diff, 16'h0001);
      check("hold_flags", f4, ref_flags(16'h0000, 16'hFFFF, 0));

      // Back-to-back: new start sampled in the DONE cycle
      launch(0, 16'h1000, 16'h2000, 0);
      wait_check(0, 16'h1000, 16'h2000, 0, "b2b_first", 0);
      launch(0, 16'h3000, 16'h2FFF, 1);
      wait_check(0, 16'h3000, 16'h2FFF, 1, "b2b_second", 1);

      // Start pulses and operand changes while running are ignored
      launch(0, 16'hA5A5, 16'h5A5A, 1);
      iStart4 = 1'b1; iA = 16'h0000; iB = 16'hFFFF; iSigned = 1'b0;
      @(posedge iClk); #1;
      check("midrun_busy", d4_busy, 1);
      @(posedge iClk); #1;
      iStart4 = 1'b0;
      @(posedge iClk); #1;
      check("midrun_no_early_done", d4_done, 0);
      @(posedge iClk); #1;
      check("midrun_done", d4_done, 1);
      check("midrun_diff", d4_diff, 16'hA5A5 - 16'h5A5A);
      check("midrun_flags", f4, ref_flags(16'hA5A5, 16'h5A5A, 1));
      extra = 0;
      repeat (8) begin
         @(posedge iClk); #1;
         if (d4_done) extra++;
      end
      check("midrun_extra_done", extra, 0);

      // Reset after two slices aborts the compare
      launch(0, 16'h0F0F, 16'h0E0E, 0);
      repeat (2) @(posedge iClk);
      #1;
      iRst = 1'b1;
      #1;
      check("abort_outputs", {d4_busy, d4_done, d4_diff, f4}, 0);
      @(posedge iClk); #1;
      iRst = 1'b0;
      extra = 0;
      repeat (8) begin
         @(posedge iClk); #1;
         if (d4_done) extra++;
      end
      check("abort_no_done", extra, 0);
      check("abort_state_idle", d4_state, ST_IDLE);
      launch(0, 16'h0F0F, 16'h0E0E, 0); wait_check(0, 16'h0F0F, 16'h0E0E, 0, "after_abort", 1);

      // Randomized compares; operands are scrambled after launch to prove latching
      for (int i = 0; i < 40; i++) begin
         a  = 16'($urandom);
         sg = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 16'h8000;
            2:       b = a + 16'($urandom_range(0, 2)) - 16'd1;
            default: b = 16'($urandom);
         endcase
         launch(0, a, b, sg);
         iA = 16'($urandom); iB = 16'($urandom); iSigned = ~sg;
         wait_check(0, a, b, sg, $sformatf("rand%0d", i), 0);
         check($sformatf("rand%0d_onehot", i), $countones({d4_equ, d4_gth, d4_lth}), 1);
         ha = a; hb = b;
         @(posedge iClk); #1;
      end
      check("rand_last_hold", d4_diff, ha - hb);

      // Single-slice instance: result one cycle after start
      launch(1, 16'h8000, 16'h0001, 0); wait_check(1, 16'h8000, 16'h0001, 0, "w_u_8000", 1);
      launch(1, 16'h8000, 16'h0001, 1); wait_check(1, 16'h8000, 16'h0001, 1, "w_s_8000", 1);
      launch(1, 16'hBEEF, 16'hBEEF, 1); wait_check(1, 16'hBEEF, 16'hBEEF, 1, "w_beef", 1);
      launch(1, 16'h7FFF, 16'h8000, 1); wait_check(1, 16'h7FFF, 16'h8000, 1, "w_s_7fff", 1);
      for (int i = 0; i < 10; i++) begin
         a  = 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
         sg = 1'($urandom_range(0, 1));
         launch(1, a, b, sg);
         wait_check(1, a, b, sg, $sformatf("w_rand%0d", i), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
